// File: rtl/mem_arbiter.sv
// Data memory arbiter: shares one memory port between MEM-stage loads/stores and a debug port.
// Define MEM_ARB_STARVE_GUARD_EN to let debug preempt after STARVE_MAX pipeline grants.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        pipe_mem_read_i,
  input  logic        pipe_mem_write_i,
  input  logic [1:0]  pipe_load_mode_i,
  input  logic [31:0] pipe_address_i,
  input  logic [31:0] pipe_write_data_i,
  output logic [31:0] pipe_read_data_o,
  output logic        pipe_stall_o,

  input  logic        dbg_req_i,
  input  logic        dbg_write_i,
  input  logic [31:0] dbg_address_i,
  input  logic [31:0] dbg_write_data_i,
  output logic [31:0] dbg_read_data_o,
  output logic        dbg_ack_o,

  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [1:0]  mem_load_mode_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  input  logic [31:0] mem_read_data_i
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  waitCnt_q;
  logic              ownerDbg_q;
  logic              isWrite_q;
  logic              memRead_q;
  logic              memWrite_q;
  logic [1:0]        memMode_q;
  logic [31:0]       memAddr_q;
  logic [31:0]       memWdata_q;
  logic [31:0]       pipeRdata_q;
  logic [31:0]       dbgRdata_q;

  logic              pipeReq;
  logic              forceDbg;
  logic              grantPipe;
  logic              grantDbg;

  assign pipeReq = pipe_mem_read_i | pipe_mem_write_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starveCnt_q;
  logic [STARVE_W-1:0] starveCnt_d;

  assign forceDbg = dbg_req_i && (starveCnt_q >= STARVE_LIM);

  // Counts pipeline wins while debug is kept waiting; any debug grant starts over.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (grantDbg) begin
      starveCnt_d = '0;
    end else if (grantPipe && dbg_req_i && (starveCnt_q < STARVE_LIM)) begin
      starveCnt_d = starveCnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  assign forceDbg = 1'b0;
`endif

  always_comb begin
    grantPipe = 1'b0;
    grantDbg  = 1'b0;
    if (state_q == IDLE) begin
      if (dbg_req_i && (!pipeReq || forceDbg)) begin
        grantDbg = 1'b1;
      end else if (pipeReq) begin
        grantPipe = 1'b1;
      end
    end
  end

  // Strobes and the address/data bus come straight from these registers, so
  // requester inputs never reach the memory port combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      ownerDbg_q  <= 1'b0;
      isWrite_q   <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      memMode_q   <= 2'b00;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      pipeRdata_q <= '0;
      dbgRdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantDbg) begin
            ownerDbg_q <= 1'b1;
            isWrite_q  <= dbg_write_i;
            memRead_q  <= !dbg_write_i;
            memWrite_q <= dbg_write_i;
            memMode_q  <= 2'b00;
            memAddr_q  <= dbg_address_i;
            memWdata_q <= dbg_write_data_i;
            waitCnt_q  <= CNT_LOAD;
            state_q    <= ACCESS;
          end else if (grantPipe) begin
            // A store wins when the stage asserts both read and write.
            ownerDbg_q <= 1'b0;
            isWrite_q  <= pipe_mem_write_i;
            memRead_q  <= pipe_mem_read_i && !pipe_mem_write_i;
            memWrite_q <= pipe_mem_write_i;
            memMode_q  <= pipe_load_mode_i;
            memAddr_q  <= pipe_address_i;
            memWdata_q <= pipe_write_data_i;
            waitCnt_q  <= CNT_LOAD;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (waitCnt_q == '0) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            state_q    <= DONE;
            if (!isWrite_q) begin
              if (ownerDbg_q) begin
                dbgRdata_q <= mem_read_data_i;
              end else begin
                pipeRdata_q <= mem_read_data_i;
              end
            end
          end else begin
            waitCnt_q <= waitCnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the very cycle a request appears, so it is the one
  // output decoded from inputs; reset forces it low regardless.
  assign pipe_stall_o = rst_n && pipeReq && !((state_q == DONE) && !ownerDbg_q);
  assign dbg_ack_o    = (state_q == DONE) && ownerDbg_q;

  assign pipe_read_data_o = pipeRdata_q;
  assign dbg_read_data_o  = dbgRdata_q;
  assign mem_read_o       = memRead_q;
  assign mem_write_o      = memWrite_q;
  assign mem_load_mode_o  = memMode_q;
  assign mem_address_o    = memAddr_q;
  assign mem_write_data_o = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors plus a timeline model of each granted access.
// Builds with or without MEM_ARB_STARVE_GUARD_EN and adapts the arbitration expectations.
module tb_mem_arbiter;

  localparam int W    = 2;
  localparam int SMAX = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        pipeMemRead;
  logic        pipeMemWrite;
  logic [1:0]  pipeLoadMode;
  logic [31:0] pipeAddress;
  logic [31:0] pipeWriteData;
  logic [31:0] pipeReadData;
  logic        pipeStall;
  logic        dbgReq;
  logic        dbgWrite;
  logic [31:0] dbgAddress;
  logic [31:0] dbgWriteData;
  logic [31:0] dbgReadData;
  logic        dbgAck;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memLoadMode;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WAIT_CYCLES(W),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_mem_read_i  (pipeMemRead),
    .pipe_mem_write_i (pipeMemWrite),
    .pipe_load_mode_i (pipeLoadMode),
    .pipe_address_i   (pipeAddress),
    .pipe_write_data_i(pipeWriteData),
    .pipe_read_data_o (pipeReadData),
    .pipe_stall_o     (pipeStall),
    .dbg_req_i        (dbgReq),
    .dbg_write_i      (dbgWrite),
    .dbg_address_i    (dbgAddress),
    .dbg_write_data_i (dbgWriteData),
    .dbg_read_data_o  (dbgReadData),
    .dbg_ack_o        (dbgAck),
    .mem_read_o       (memRead),
    .mem_write_o      (memWrite),
    .mem_load_mode_o  (memLoadMode),
    .mem_address_o    (memAddress),
    .mem_write_data_o (memWriteData),
    .mem_read_data_i  (memReadData)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pr, input logic pw, input logic [1:0] mode,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic dr, input logic dw, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic [31:0] memrd);
    pipeMemRead   = pr;
    pipeMemWrite  = pw;
    pipeLoadMode  = mode;
    pipeAddress   = addr;
    pipeWriteData = wdata;
    dbgReq        = dr;
    dbgWrite      = dw;
    dbgAddress    = daddr;
    dbgWriteData  = dwdata;
    memReadData   = memrd;
  endtask

  task automatic startCycle();
    @(posedge clk);
    #1;
  endtask

  // Model: each grant is a timeline; grant cycle g gives strobes in g+1..g+W,
  // completion in g+W+1, and the arbiter is free again from g+W+2.
  int          cyc;
  bit          mActive;
  int          mGrant;
  bit          mOwnerDbg;
  bit          mWrite;
  logic [1:0]  mMode;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mPipeRd;
  logic [31:0] mDbgRd;
  int          mStarve;
  bit          pReq;
  bit          guardTrips;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; mActive = 0; mGrant = 0; mOwnerDbg = 0; mWrite = 0;
      mMode = 2'b00; mAddr = '0; mWdata = '0; mPipeRd = '0; mDbgRd = '0; mStarve = 0;
    end else begin
      if (mActive && (cyc == mGrant + W) && !mWrite) begin
        if (mOwnerDbg) mDbgRd = memReadData;
        else           mPipeRd = memReadData;
      end
      if (!mActive || (cyc >= mGrant + W + 2)) begin
        pReq = pipeMemRead || pipeMemWrite;
`ifdef MEM_ARB_STARVE_GUARD_EN
        guardTrips = dbgReq && (mStarve >= SMAX);
`else
        guardTrips = 1'b0;
`endif
        if (dbgReq && (!pReq || guardTrips)) begin
          mActive = 1; mGrant = cyc; mOwnerDbg = 1; mWrite = dbgWrite;
          mMode = 2'b00; mAddr = dbgAddress; mWdata = dbgWriteData; mStarve = 0;
        end else if (pReq) begin
          mActive = 1; mGrant = cyc; mOwnerDbg = 0; mWrite = pipeMemWrite;
          mMode = pipeLoadMode; mAddr = pipeAddress; mWdata = pipeWriteData;
          if (dbgReq) mStarve++;
        end
      end
      cyc++;
    end
  end

  bit inAcc;
  bit inDone;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      checkOutput("rstMemRead", memRead, 0);
      checkOutput("rstMemWrite", memWrite, 0);
      checkOutput("rstStall", pipeStall, 0);
      checkOutput("rstAck", dbgAck, 0);
      checkOutput("rstPipeRd", pipeReadData, 0);
      checkOutput("rstDbgRd", dbgReadData, 0);
      checkOutput("rstMemAddr", memAddress, 0);
      checkOutput("rstMemWdata", memWriteData, 0);
      checkOutput("rstMemMode", memLoadMode, 0);
    end else begin
      inAcc  = mActive && (cyc >= mGrant + 1) && (cyc <= mGrant + W);
      inDone = mActive && (cyc == mGrant + W + 1);
      checkOutput("modelMemRead", memRead, inAcc && !mWrite);
      checkOutput("modelMemWrite", memWrite, inAcc && mWrite);
      if (inAcc) begin
        checkOutput("modelMemAddr", memAddress, mAddr);
        checkOutput("modelMemMode", memLoadMode, mMode);
        if (mWrite) checkOutput("modelMemWdata", memWriteData, mWdata);
      end
      checkOutput("modelStall", pipeStall, (pipeMemRead || pipeMemWrite) && !(inDone && !mOwnerDbg));
      checkOutput("modelAck", dbgAck, inDone && mOwnerDbg);
      checkOutput("modelPipeRd", pipeReadData, mPipeRd);
      checkOutput("modelDbgRd", dbgReadData, mDbgRd);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        pr;
    logic        pw;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dr;
    logic        dw;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] memrd;
    logic [31:0] expPipe;
    logic [31:0] expDbg;
  } vec_t;

  vec_t vecs[3];
  int   lat;
  int   ackSeen;
  int   pipeDone;
  bit   found;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b01, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
                32'h01020304, 32'hCAFEF00D, 32'h01020304};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 32'h108, 32'h55AA55AA, 1'b0, 1'b0, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'hCAFEF00D, 32'h01020304};

    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] pipeline load");
    startCycle();
    applyStimulus(1, 0, 2'b10, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1StallN", pipeStall, 1);
    checkOutput("t1ReadN", memRead, 0);
    @(negedge clk);
    checkOutput("t1ReadN1", memRead, 1);
    checkOutput("t1AddrN1", memAddress, 32'h10);
    checkOutput("t1ModeN1", memLoadMode, 2'b10);
    checkOutput("t1StallN1", pipeStall, 1);
    @(negedge clk);
    checkOutput("t1ReadN2", memRead, 1);
    checkOutput("t1StallN2", pipeStall, 1);
    @(negedge clk);
    checkOutput("t1ReadN3", memRead, 0);
    checkOutput("t1StallN3", pipeStall, 0);
    checkOutput("t1PipeRd", pipeReadData, 32'hDEADBEEF);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] debug write");
    startCycle();
    applyStimulus(0, 0, 2'b01, 0, 0, 1, 1, 32'h20, 32'h12345678, 0);
    @(negedge clk);
    checkOutput("t2AckN", dbgAck, 0);
    @(negedge clk);
    checkOutput("t2WriteN1", memWrite, 1);
    checkOutput("t2ReadN1", memRead, 0);
    checkOutput("t2ModeN1", memLoadMode, 2'b00);
    checkOutput("t2AddrN1", memAddress, 32'h20);
    checkOutput("t2WdataN1", memWriteData, 32'h12345678);
    @(negedge clk);
    checkOutput("t2WriteN2", memWrite, 1);
    checkOutput("t2AckN2", dbgAck, 0);
    @(negedge clk);
    checkOutput("t2WriteN3", memWrite, 0);
    checkOutput("t2AckN3", dbgAck, 1);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2AckN4", dbgAck, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 3; i++) begin
      startCycle();
      applyStimulus(vecs[i].pr, vecs[i].pw, vecs[i].mode, vecs[i].addr, vecs[i].wdata,
                    vecs[i].dr, vecs[i].dw, vecs[i].daddr, vecs[i].dwdata, vecs[i].memrd);
      repeat (W + 2) @(negedge clk);
      checkOutput($sformatf("vec%0dPipeRd", i), pipeReadData, vecs[i].expPipe);
      checkOutput($sformatf("vec%0dDbgRd", i), dbgReadData, vecs[i].expDbg);
      startCycle();
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    end

    $display("[TB] simultaneous pipeline and debug");
    startCycle();
    applyStimulus(1, 0, 2'b00, 32'h40, 0, 1, 0, 32'h30, 0, 32'h0BADF00D);
`ifdef MEM_ARB_STARVE_GUARD_EN
    pipeDone = 0;
    found    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbgAck) begin
        found = 1;
        checkOutput("t4StallDuringDbg", pipeStall, 1);
        break;
      end
      if (!pipeStall) pipeDone++;
    end
    checkOutput("t4AckSeen", found, 1);
    checkOutput("t4PipeGrantsBeforeDbg", pipeDone, SMAX);
    checkOutput("t4DbgRd", dbgReadData, 32'h0BADF00D);
`else
    ackSeen = 0;
    repeat (4 * (W + 2)) begin
      @(negedge clk);
      if (dbgAck) ackSeen++;
    end
    checkOutput("t3NoAckWhilePipe", ackSeen, 0);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 1, 0, 32'h30, 0, 32'h0BADF00D);
    for (lat = 0; lat < 12; lat++) begin
      @(negedge clk);
      if (dbgAck) break;
    end
    checkOutput("t3AckLatency", lat, W + 1);
    checkOutput("t3DbgRd", dbgReadData, 32'h0BADF00D);
`endif
    checkOutput("t3PipeRd", pipeReadData, 32'h0BADF00D);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    $display("[TB] read and write together");
    startCycle();
    applyStimulus(1, 1, 2'b00, 32'h60, 32'hA5A5A5A5, 0, 0, 0, 0, 32'hFFFF0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6WriteN1", memWrite, 1);
    checkOutput("t6ReadN1", memRead, 0);
    checkOutput("t6WdataN1", memWriteData, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6StallN3", pipeStall, 0);
    checkOutput("t6PipeRdKept", pipeReadData, 32'h0BADF00D);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during access");
    startCycle();
    applyStimulus(1, 0, 2'b00, 32'h70, 0, 0, 0, 0, 0, 32'h11112222);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5StrobeBeforeReset", memRead, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5ReadDropped", memRead, 0);
    checkOutput("t5WriteDropped", memWrite, 0);
    checkOutput("t5StallDropped", pipeStall, 0);
    checkOutput("t5AckLow", dbgAck, 0);
    checkOutput("t5PipeRdCleared", pipeReadData, 0);
    checkOutput("t5AddrCleared", memAddress, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ackSeen = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (dbgAck) ackSeen++;
    end
    checkOutput("t5NoAckAfterReset", ackSeen, 0);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 1, 0, 32'h50, 0, 32'h13572468);
    for (lat = 0; lat < 12; lat++) begin
      @(negedge clk);
      if (dbgAck) break;
    end
    checkOutput("t5AckLatency", lat, W + 1);
    checkOutput("t5DbgRd", dbgReadData, 32'h13572468);
    startCycle();
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
